// File: rtl/edac_pkg.sv
// Shared definitions for the EDAC error monitor: alert FSM state encoding,
// event-type tags stored in the log MSB, and the log entry width helper.
// No logic; imported by edac_err_monitor and its sub-module.
package edac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALERT = 2'd1,
    ST_FATAL = 2'd2
  } state_e;

  localparam logic EVT_SEC = 1'b0;
  localparam logic EVT_DED = 1'b1;

  // Log entry = {type, data}
  function automatic int log_width(input int data_bits);
    return data_bits + 1;
  endfunction

endpackage

// File: rtl/edac_log_fifo.sv
// Purpose: first-word-fall-through synchronous FIFO for the error event log.
// Latency: a push is visible at rd_dat_o the cycle after it is accepted; head shows continuously.
// Backpressure: push on full is refused unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the FIFO (wins over push/pop);
//        push_i/push_dat_i write side; pop_i removes head; rd_dat_o head entry (0 when empty);
//        full_o/empty_o occupancy flags.
module edac_log_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot a same-cycle push needs, so full does not block it.
  assign do_push = push_i && (!full_o || do_pop);

  // Stale storage is hidden so an empty log always reads as zero.
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/edac_err_monitor.sv
// Purpose: counts SEC/DED events from the EDAC decoder, logs them, and raises alert/fatal interrupts.
// Latency: counters, FSM outputs and log head update one cycle after the sampled event.
// Backpressure: none upstream; events arriving with the log full are dropped and flagged in Log_ovf.
// Ports: clk/reset_b clock and async active-low reset; *_14p decoder data, flags and valid;
//        Irq_ack acknowledges ALERT; Clear resets counters/log/overflow/FSM; Log_rd_en pops the log;
//        Sec/Ded_count_15p saturating counts; Irq_15p/Fatal_15p interrupt state;
//        Log_rd_data/Log_empty/Log_full/Log_ovf event log interface.
module edac_err_monitor
  import edac_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CNT_BITS   = 8,
  parameter int LOG_DEPTH  = 4,
  parameter int SEC_THRESH = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [DATA_BITS-1:0] Data_in_14p,
  input  logic                 EDACerr1_14p,
  input  logic                 EDACerr2_14p,
  input  logic                 Data_valid_14p,
  input  logic                 Irq_ack,
  input  logic                 Clear,
  input  logic                 Log_rd_en,
  output logic [CNT_BITS-1:0]  Sec_count_15p,
  output logic [CNT_BITS-1:0]  Ded_count_15p,
  output logic                 Irq_15p,
  output logic                 Fatal_15p,
  output logic [DATA_BITS:0]   Log_rd_data,
  output logic                 Log_empty,
  output logic                 Log_full,
  output logic                 Log_ovf
);

  localparam int                  LOG_W   = log_width(DATA_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] THRESH  = CNT_BITS'(SEC_THRESH);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] sec_q, sec_d, ded_q, ded_d;
  logic [CNT_BITS-1:0] sec_inc, ded_inc;
  logic                ovf_q, ovf_d;
  logic                ev_sec, ev_ded, ev_any;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LOG_W-1:0]    fifo_dat;

  // DED dominates when both flags are raised.
  assign ev_ded = Data_valid_14p && EDACerr2_14p;
  assign ev_sec = Data_valid_14p && EDACerr1_14p && !EDACerr2_14p;
  assign ev_any = ev_sec || ev_ded;

  assign sec_inc = (sec_q == CNT_MAX) ? sec_q : sec_q + 1'b1;
  assign ded_inc = (ded_q == CNT_MAX) ? ded_q : ded_q + 1'b1;

  // Clear also flushes the FIFO, so gating here just keeps intent explicit.
  assign fifo_push = ev_any && !Clear;
  assign fifo_pop  = Log_rd_en && !Clear;
  assign fifo_dat  = {(ev_ded ? EVT_DED : EVT_SEC), Data_in_14p};

  edac_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk_i      (clk),
    .rst_ni     (reset_b),
    .flush_i    (Clear),
    .push_i     (fifo_push),
    .push_dat_i (fifo_dat),
    .pop_i      (fifo_pop),
    .rd_dat_o   (Log_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      ded_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    ded_d     = ded_q;
    ovf_d     = ovf_q;
    Irq_15p   = (state_q != ST_IDLE);
    Fatal_15p = (state_q == ST_FATAL);

    if (Clear) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      ded_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (ev_sec) sec_d = sec_inc;
      if (ev_ded) ded_d = ded_inc;
      // Full only drops the event when no same-cycle pop makes room.
      if (ev_any && fifo_full && !Log_rd_en) ovf_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (ev_ded) begin
            state_d = ST_FATAL;
          end else if (ev_sec && (sec_inc >= THRESH)) begin
            state_d = ST_ALERT;
          end
        end
        ST_ALERT: begin
          if (ev_ded) begin
            state_d = ST_FATAL;
          end else if (Irq_ack) begin
            // Restart the threshold window; a concurrent SEC is dropped from the count.
            state_d = ST_IDLE;
            sec_d   = '0;
          end
        end
        ST_FATAL: state_d = ST_FATAL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign Sec_count_15p = sec_q;
  assign Ded_count_15p = ded_q;
  assign Log_empty     = fifo_empty;
  assign Log_full      = fifo_full;
  assign Log_ovf       = ovf_q;

endmodule

// File: doc/edac_err_monitor.md
Name: edac_err_monitor

Overview:
- Downstream stage of the EDAC decoder; consumes the 14p data word and single/double error flags.
- Keeps saturating single-error (SEC) and double-error (DED) counters.
- Logs error events in a small first-word-fall-through FIFO.
- Raises an interrupt through a three-state alert FSM: threshold alert with acknowledge, fatal lock with explicit clear.

Parameters:
- DATA_BITS, 8, width of the corrected data word from the decoder.
- CNT_BITS, 8, width of each saturating error counter.
- LOG_DEPTH, 4, event-log FIFO entries; must be a power of 2, >= 2.
- SEC_THRESH, 16, SEC count that triggers the alert; must satisfy 1 <= SEC_THRESH <= 2^CNT_BITS-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_b  in  1  asynchronous active-low reset.
- Data_in_14p  in  DATA_BITS  corrected data from the decoder.
- EDACerr1_14p  in  1  single error corrected.
- EDACerr2_14p  in  1  double error detected.
- Data_valid_14p  in  1  qualifies the three 14p inputs for one cycle.
- Irq_ack  in  1  acknowledges the threshold alert.
- Clear  in  1  clears counters, log, overflow flag and FSM.
- Log_rd_en  in  1  pops the log head.
- Sec_count_15p  out  CNT_BITS  saturating SEC count.
- Ded_count_15p  out  CNT_BITS  saturating DED count.
- Irq_15p  out  1  interrupt; high in ALERT or FATAL.
- Fatal_15p  out  1  high in FATAL.
- Log_rd_data  out  DATA_BITS+1  head entry: MSB = type (1 = DED, 0 = SEC), LSBs = data.
- Log_empty  out  1  FIFO empty.
- Log_full  out  1  FIFO full.
- Log_ovf  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset: all counters 0, FIFO empty (Log_empty=1, Log_full=0, Log_rd_data=0), Log_ovf=0, FSM=IDLE, Irq_15p=0, Fatal_15p=0.
- Event classification, only when Data_valid_14p=1:
  - EDACerr2_14p=1 is a DED event, whatever EDACerr1_14p is (DED wins).
  - Otherwise EDACerr1_14p=1 is a SEC event.
  - Otherwise no event.
  - Flags with Data_valid_14p=0 are ignored.
- Counters:
  - The matching counter increments on the clock edge that samples the event, so the new value is visible the next cycle (1-cycle latency).
  - Each counter saturates at 2^CNT_BITS-1 and never wraps.
- Log:
  - Each event pushes {type, Data_in_14p} if the FIFO is not full.
  - If the FIFO is full, the event is dropped and Log_ovf is set; it stays set until Clear or reset. Counters still increment.
  - FWFT: Log_rd_data always shows the head entry. Log_rd_en pops when not empty; Log_rd_en on empty is ignored.
  - Push and pop in the same cycle:
    - when full: both take effect, and the event is not dropped;
    - when empty: the push takes effect and the pop is ignored.
- FSM states (registered; Irq/Fatal decoded from state):
  - IDLE → FATAL on a DED event.
  - Else IDLE → ALERT when the SEC event makes the next SEC count >= SEC_THRESH. Irq_15p goes high the cycle after that event.
  - ALERT → FATAL on a DED event.
  - Else ALERT → IDLE on Irq_ack. This also clears Sec_count_15p to 0 so the threshold window restarts. A SEC event in the same cycle as Irq_ack is lost from the counter but still logged.
  - FATAL stays FATAL until Clear; Irq_ack has no effect.
  - Irq_ack in IDLE is ignored.
- Clear (synchronous, 1 cycle): counters=0, FIFO flushed, Log_ovf=0, FSM=IDLE. Clear has priority over a same-cycle event, Irq_ack and Log_rd_en; that event is neither counted nor logged.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Logged contents are lost.

Decomposition:
- Shared package edac_pkg: state encoding (ST_IDLE, ST_ALERT, ST_FATAL), event-type constants (EVT_SEC=0, EVT_DED=1), log entry width function DATA_BITS+1.
- One sub-module: edac_log_fifo, a parameterised FWFT synchronous FIFO (width, depth) with push, pop, full, empty and flush.
- Counters, overflow flag and FSM stay in edac_err_monitor.

Test Plan:
- Reset, then 3 SEC events (data 8'hA5, 8'h5A, 8'h3C) → Sec_count_15p=3; log pops in order 9'h0A5, 9'h05A, 9'h03C; Irq_15p=0.
- SEC_THRESH=16; 16 SEC events → Irq_15p rises the cycle after the 16th. Irq_ack → Irq_15p=0 next cycle, Sec_count_15p=0.
- DED event (data 8'hFF) in ALERT → Fatal_15p=1, Irq_15p=1, Ded_count_15p=1, log entry 9'h1FF. Irq_ack has no effect; Clear → IDLE, all counts 0, Log_empty=1.
- Five events with LOG_DEPTH=4 and no reads → Log_full=1, Log_ovf=1, 4 entries retained. Push with simultaneous Log_rd_en when full → no drop, Log_full stays 1.
- CNT_BITS=4, SEC_THRESH=15, Irq_ack held low; 20 SEC events → Sec_count_15p saturates at 4'hF, never wraps.
- Clear asserted in the same cycle as a DED event → FSM stays IDLE, Ded_count_15p=0, Log_empty=1. Mid-sequence reset_b low → all outputs at reset values asynchronously.
